tdm_demux: RTL and testbench

Time-division demultiplexer. It is the receive-side inverse of the team's N:1 MUX. A serial slot stream, produced by a MUX whose select steps 0..N-1, is captured slot by slot and rebuilt into a parallel N-slot word. It locks on a frame marker, tracks the slot index with a counter, and presents each complete frame with a one-cycle valid strobe. It also flags frame misalignment.

---
 rtl/tdm_demux.sv | 98 +++++++++
 tb/tb_tdm_demux.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds an N-slot parallel frame from a serial TDM slot
// stream, locking on Frame. Ports: Clk, Reset_n, In/In_Valid/Frame in;
// Out/Out_Valid, Sel, Locked, Sync_Err out.
module tdm_demux #(
  parameter int WIDTH = 1,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   In,
  input  logic               In_Valid,
  input  logic               Frame,
  output logic [N*WIDTH-1:0] Out,
  output logic               Out_Valid,
  output logic [SEL_W-1:0]   Sel,
  output logic               Locked,
  output logic               Sync_Err
);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t               state, state_d;
  logic [SEL_W-1:0]     sel_d;
  logic [N*WIDTH-1:0]   shadow, shadow_d;
  logic [N*WIDTH-1:0]   out_d;
  logic                 ov_d, se_d, lk_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= HUNT;
      Sel       <= '0;
      shadow    <= '0;
      Out       <= '0;
      Out_Valid <= 1'b0;
      Sync_Err  <= 1'b0;
      Locked    <= 1'b0;
    end else begin
      state     <= state_d;
      Sel       <= sel_d;
      shadow    <= shadow_d;
      Out       <= out_d;
      Out_Valid <= ov_d;
      Sync_Err  <= se_d;
      Locked    <= lk_d;
    end
  end

  always_comb begin
    state_d  = state;
    sel_d    = Sel;
    shadow_d = shadow;
    out_d    = Out;
    ov_d     = 1'b0;
    se_d     = 1'b0;
    if (In_Valid) begin
      unique case (state)
        HUNT: begin
          if (Frame) begin
            shadow_d[WIDTH-1:0] = In;
            sel_d   = ONE;
            state_d = RUN;
          end
        end
        RUN: begin
          if (Frame && Sel != '0) begin
            // Misaligned marker: restart the frame at slot 0.
            se_d  = 1'b1;
            shadow_d[WIDTH-1:0] = In;
            sel_d = ONE;
          end else begin
            for (int k = 0; k < N; k++) begin
              if (SEL_W'(k) == Sel)
                shadow_d[k*WIDTH +: WIDTH] = In;
            end
            if (Sel == LAST) begin
              // Publish with the last slot merged in this same edge.
              out_d = shadow_d;
              ov_d  = 1'b1;
              sel_d = '0;
            end else begin
              sel_d = Sel + ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    lk_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: vector table plus output scoreboard for tdm_demux.
// Drives on Clk low, samples 1ns after the rising edge.
module tb_tdm_demux;
  localparam int W  = 1;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [W-1:0]  In = '0;
  logic          In_Valid = 1'b0;
  logic          Frame = 1'b0;
  logic [N*W-1:0] Out;
  logic          Out_Valid;
  logic [SW-1:0] Sel;
  logic          Locked;
  logic          Sync_Err;

  tdm_demux #(.WIDTH(W), .N(N), .SEL_W(SW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In(In),
    .In_Valid(In_Valid), .Frame(Frame),
    .Out(Out), .Out_Valid(Out_Valid), .Sel(Sel),
    .Locked(Locked), .Sync_Err(Sync_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       i, v, f;
    logic [1:0] sel;
    logic       lk, ov, se;
    logic [3:0] out;
  } vec_t;

  vec_t tv[$];
  logic [N*W-1:0] sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(logic i, logic v, logic f);
    @(negedge Clk);
    In = i; In_Valid = v; Frame = f;
    @(posedge Clk);
    #1;
  endtask

  task automatic sb_check();
    if (Out_Valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected got=%0h exp=none", Out);
      end else begin
        chk("sb_out", {28'd0, Out}, {28'd0, sb.pop_front()});
      end
    end
  endtask

  task automatic add(logic i, v, f, logic [1:0] s,
                     logic lk, ov, se, logic [3:0] o);
    vec_t t;
    t.i = i; t.v = v; t.f = f; t.sel = s;
    t.lk = lk; t.ov = ov; t.se = se; t.out = o;
    tv.push_back(t);
  endtask

  task automatic chk_all(string nm, logic [1:0] s, logic lk,
                         logic ov, logic se, logic [3:0] o);
    chk({nm, "_sel"}, {30'd0, Sel}, {30'd0, s});
    chk({nm, "_lk"}, {31'd0, Locked}, {31'd0, lk});
    chk({nm, "_ov"}, {31'd0, Out_Valid}, {31'd0, ov});
    chk({nm, "_se"}, {31'd0, Sync_Err}, {31'd0, se});
    chk({nm, "_out"}, {28'd0, Out}, {28'd0, o});
  endtask

  initial begin
    // HUNT discard
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 4'h0);
    // frame 1,0,1,1 then 0,0,0,1
    add(1, 1, 1, 1, 1, 0, 0, 4'h0);
    add(0, 1, 0, 2, 1, 0, 0, 4'h0);
    add(1, 1, 0, 3, 1, 0, 0, 4'h0);
    add(1, 1, 0, 0, 1, 1, 0, 4'hD);
    add(0, 0, 0, 0, 1, 0, 0, 4'hD);
    add(0, 1, 1, 1, 1, 0, 0, 4'hD);
    add(0, 1, 0, 2, 1, 0, 0, 4'hD);
    add(0, 1, 0, 3, 1, 0, 0, 4'hD);
    add(1, 1, 0, 0, 1, 1, 0, 4'h8);
    // gapped 1,0,1,1; Frame without In_Valid ignored
    add(1, 1, 1, 1, 1, 0, 0, 4'h8);
    add(0, 0, 1, 1, 1, 0, 0, 4'h8);
    add(1, 0, 0, 1, 1, 0, 0, 4'h8);
    add(0, 1, 0, 2, 1, 0, 0, 4'h8);
    add(0, 0, 0, 2, 1, 0, 0, 4'h8);
    add(0, 0, 1, 2, 1, 0, 0, 4'h8);
    add(1, 1, 0, 3, 1, 0, 0, 4'h8);
    add(1, 0, 0, 3, 1, 0, 0, 4'h8);
    add(0, 0, 0, 3, 1, 0, 0, 4'h8);
    add(1, 1, 0, 0, 1, 1, 0, 4'hD);
    add(0, 0, 0, 0, 1, 0, 0, 4'hD);
    // misalignment then 0,1,1,1
    add(1, 1, 1, 1, 1, 0, 0, 4'hD);
    add(1, 1, 0, 2, 1, 0, 0, 4'hD);
    add(0, 1, 1, 1, 1, 0, 1, 4'hD);
    add(1, 1, 0, 2, 1, 0, 0, 4'hD);
    add(1, 1, 0, 3, 1, 0, 0, 4'hD);
    add(1, 1, 0, 0, 1, 1, 0, 4'hE);
    add(0, 0, 0, 0, 1, 0, 0, 4'hE);

    // reset with random stimulus
    Reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      In = W'($urandom_range(1, 0));
      In_Valid = 1'($urandom_range(1, 0));
      Frame = 1'($urandom_range(1, 0));
      @(posedge Clk);
      #1;
      chk_all("rst", 0, 0, 0, 0, 4'h0);
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    Frame = 1'b0;
    Reset_n = 1'b1;
    step(0, 0, 0);
    chk_all("rel", 0, 0, 0, 0, 4'h0);

    for (int k = 0; k < tv.size(); k++) begin
      if (tv[k].ov) sb.push_back(tv[k].out);
      step(tv[k].i, tv[k].v, tv[k].f);
      chk_all($sformatf("v%0d", k), tv[k].sel, tv[k].lk,
              tv[k].ov, tv[k].se, tv[k].out);
      sb_check();
    end

    // reset mid-frame
    step(1, 1, 1);
    step(0, 1, 0);
    chk_all("mid", 2, 1, 0, 0, 4'hE);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 chk_all("async", 0, 0, 0, 0, 4'h0);
    #1 Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0);
      chk_all("post", 0, 0, 0, 0, 4'h0);
      sb_check();
    end
    step(1, 1, 1);
    chk_all("relock", 1, 1, 0, 0, 4'h0);
    step(0, 0, 0);
    sb_check();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
